// File: rtl/vrf_pkg.sv
// Shared definitions for the VRF write-port scheduler: requester indices,
// FSM state type and default tuning parameters.
package vrf_pkg;

   localparam int unsigned REQ_LD   = 0;
   localparam int unsigned REQ_VALU = 1;
   localparam int unsigned REQ_TC   = 2;

   localparam int unsigned AGE_MAX_DEF   = 4;
   localparam int unsigned BURST_MAX_DEF = 8;

   typedef enum logic [0:0] {
      StIdle,
      StOwn
   } vrf_state_e;

endpackage

// File: rtl/vrf_wr_sched_if.sv
// Request/grant bundle between the VRF write-port requesters and the scheduler.
interface vrf_wr_sched_if #(
   parameter int unsigned NREQ = 3
) ();

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] last;
   logic [NREQ-1:0] gnt;
   logic            busy;
   logic            preempt;

   modport master (
      output req,
      output last,
      input  gnt,
      input  busy,
      input  preempt
   );

   modport slave (
      input  req,
      input  last,
      output gnt,
      output busy,
      output preempt
   );

endinterface

// File: rtl/vrf_prio_pick.sv
// One-hot winner select: lowest-index starving requester, else fixed priority,
// ignoring requesters in the exclude mask.
module vrf_prio_pick #(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned AW      = 3,
   parameter int unsigned AGE_MAX = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ-1:0]         excl_i,
   input  logic [NREQ-1:0][AW-1:0] age_i,
   output logic [NREQ-1:0]         pick_o,
   output logic                    valid_o
);

   localparam logic [AW-1:0] AgeSat = AW'(AGE_MAX);

   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] starve;
   logic [NREQ-1:0] pool;

   always_comb begin
      cand   = req_i & ~excl_i;
      starve = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         starve[i] = cand[i] && (age_i[i] == AgeSat);
      end
      pool    = (|starve) ? starve : cand;
      // Isolate the lowest set bit of the pool.
      pick_o  = pool & (~pool + NREQ'(1));
      valid_o = |cand;
   end

endmodule

// File: rtl/vrf_wr_sched.sv
// VRF write-port scheduler: one owner at a time, burst-limited under contention,
// starvation-aware arbitration with zero-bubble handoff.
module vrf_wr_sched
   import vrf_pkg::*;
#(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned AGE_MAX   = AGE_MAX_DEF,
   parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
   input  logic           clk,
   input  logic           nrst,
   vrf_wr_sched_if.slave  bus
);

   localparam int unsigned AW = $clog2(AGE_MAX + 1);
   localparam int unsigned CW = $clog2(BURST_MAX + 1);
   localparam logic [AW-1:0] AgeSat    = AW'(AGE_MAX);
   localparam logic [CW-1:0] BurstSat  = CW'(BURST_MAX);
   localparam logic [CW-1:0] BurstLast = CW'(BURST_MAX - 1);

   vrf_state_e              state_q, state_d;
   logic [NREQ-1:0]         gnt_q, gnt_d;
   logic                    busy_q, busy_d;
   logic                    preempt_q, preempt_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NREQ-1:0][AW-1:0] age_q, age_d;

   logic [NREQ-1:0] beat;
   logic [NREQ-1:0] excl;
   logic [NREQ-1:0] pick;
   logic            pick_vld;
   logic            own_beat;
   logic            own_last;
   logic            others;
   logic            burst_end;
   logic            rel;
   logic            arb;

   always_comb begin
      beat      = gnt_q & bus.req;
      own_beat  = |beat;
      own_last  = |(beat & bus.last);
      others    = |(bus.req & ~gnt_q);
      // cnt_q counts earlier beats, so this beat is the BURST_MAX-th one.
      burst_end = own_beat && others && (cnt_q >= BurstLast);
      rel       = (state_q == StOwn) && (own_last || !own_beat || burst_end);
      arb       = (state_q == StIdle) || rel;
      excl      = (state_q == StOwn) ? gnt_q : '0;
   end

   vrf_prio_pick #(
      .NREQ    (NREQ),
      .AW      (AW),
      .AGE_MAX (AGE_MAX)
   ) u_pick (
      .req_i   (bus.req),
      .excl_i  (excl),
      .age_i   (age_q),
      .pick_o  (pick),
      .valid_o (pick_vld)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;

      if (arb) begin
         cnt_d = '0;
         if (pick_vld) begin
            gnt_d   = pick;
            state_d = StOwn;
         end else if (state_q == StOwn && own_beat) begin
            // Sole requester finishing a burst keeps the port with a fresh count.
            gnt_d = gnt_q;
         end else begin
            gnt_d   = '0;
            state_d = StIdle;
         end
         preempt_d = rel && burst_end && !own_last;
      end else if (own_beat && cnt_q != BurstSat) begin
         cnt_d = cnt_q + CW'(1);
      end

      busy_d = |gnt_d;

      age_d = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (bus.req[i] && !gnt_q[i]) begin
            age_d[i] = (age_q[i] == AgeSat) ? AgeSat : age_q[i] + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= StIdle;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
         cnt_q     <= '0;
         age_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
         cnt_q     <= cnt_d;
         age_q     <= age_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.preempt = preempt_q;

endmodule
